// File: rtl/wb_mailbox_slave.sv
// rtl/wb_mailbox_slave.sv - Wishbone classic mailbox slave with host TX / core RX FIFOs
//
// Ports:
//   wb_clk_i, wb_rst_ni           clock, synchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i    Wishbone request
//   wbs_adr_i, wbs_dat_i          byte address, write data
//   wbs_ack_o, wbs_dat_o          single-cycle ack, read data (0 when not acking)
//   tx_data/tx_valid/tx_ready     host-to-core stream (head of TX FIFO)
//   rx_data/rx_valid/rx_ready     core-to-host stream (into RX FIFO)
//   irq                           level interrupt: irq_en & RX FIFO not empty
//
// Register map (offset = wbs_adr_i[3:2]):
//   0x0 DATA_TX  W: push, R: 0
//   0x4 DATA_RX  R: pop head (0 + UNF when empty), W: ignored
//   0x8 STATUS   {6'b0, unf, ovf, rx_count, tx_count, 4'b0, rx_empty, rx_full, tx_empty, tx_full}
//   0xC CTRL     [0] irq_en, [1] flush (W1), [2] clear sticky flags (W1); needs wbs_sel_i[0]
module wb_mailbox_slave #(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int          DEPTH     = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [CW-1:0] tx_count;
    logic [31:0]   rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0] rx_count;

    logic ctrl_irq_en;
    logic ovf;
    logic unf;

    logic        hit;
    logic [1:0]  off;
    logic        bus_wr;
    logic        bus_rd;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic        tx_push_req, rx_pop_req;
    logic        ctrl_wr, flush, clr_flags;
    logic [31:0] status;
    logic [31:0] rdata;

    // Low address bits and upper byte selects carry no meaning in this window.
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0]};

    // ~wbs_ack_o blocks re-acceptance of a request still held during its ack cycle.
    assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]) & ~wbs_ack_o;
    assign off    = wbs_adr_i[3:2];
    assign bus_wr = hit & wbs_we_i;
    assign bus_rd = hit & ~wbs_we_i;

    assign tx_full  = (tx_count == CW'(DEPTH));
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == CW'(DEPTH));
    assign rx_empty = (rx_count == '0);

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;
    assign tx_data  = tx_mem[tx_rd_ptr];

    assign tx_push_req = bus_wr && (off == 2'd0);
    assign rx_pop_req  = bus_rd && (off == 2'd1);
    assign tx_push     = tx_push_req & ~tx_full;
    assign tx_pop      = tx_valid & tx_ready;
    assign rx_push     = rx_valid & rx_ready;
    assign rx_pop      = rx_pop_req & ~rx_empty;

    assign ctrl_wr   = bus_wr && (off == 2'd3) && wbs_sel_i[0];
    assign flush     = ctrl_wr & wbs_dat_i[1];
    assign clr_flags = ctrl_wr & wbs_dat_i[2];

    assign status = {6'b0, unf, ovf, 8'(rx_count), 8'(tx_count),
                     4'b0, rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        rdata = '0;
        case (off)
            2'd1:    rdata = rx_empty ? 32'h0 : rx_mem[rx_rd_ptr];
            2'd2:    rdata = status;
            2'd3:    rdata = {31'b0, ctrl_irq_en};
            default: rdata = '0;
        endcase
    end

    // Storage arrays need no reset; pointers and counts define validity.
    always_ff @(posedge wb_clk_i) begin
        if (tx_push && !flush) tx_mem[tx_wr_ptr] <= wbs_dat_i;
        if (rx_push && !flush) rx_mem[rx_wr_ptr] <= rx_data;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else if (flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else if (flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            ctrl_irq_en <= 1'b0;
            ovf         <= 1'b0;
            unf         <= 1'b0;
            irq         <= 1'b0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= bus_rd ? rdata : 32'h0;
            if (ctrl_wr) ctrl_irq_en <= wbs_dat_i[0];
            if (clr_flags)                 ovf <= 1'b0;
            else if (tx_push_req & tx_full) ovf <= 1'b1;
            if (clr_flags)                   unf <= 1'b0;
            else if (rx_pop_req & rx_empty)  unf <= 1'b1;
            // Registered from the pre-edge state, so irq trails the FIFO by one cycle.
            irq <= ctrl_irq_en & ~rx_empty;
        end
    end

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// tb/tb_wb_mailbox_slave.sv - self-checking bench for wb_mailbox_slave
module tb_wb_mailbox_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_mailbox_slave #(.ADDR_BASE(32'h3000_0000), .DEPTH(8)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .irq(irq)
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_ack;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic acked,
                       output int lat);
        @(negedge clk);
        adr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        acked = 1'b0; rd = '0; lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (ack) begin
                acked = 1'b1; rd = rdat; lat = i;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_dat", rdat, 32'h0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'b0, rx_ready}, 32'h1);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic expect_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        acked;
        int          lat;
        bus(a, 1'b0, 32'h0, 4'hF, rd, acked, lat);
        chk({name, "_ack"}, {31'b0, acked}, 32'h1);
        chk(name, rd, exp);
    endtask

    task automatic expect_write(input string name, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        acked;
        int          lat;
        bus(a, 1'b1, d, 4'hF, rd, acked, lat);
        chk({name, "_ack"}, {31'b0, acked}, 32'h1);
    endtask

    localparam logic [31:0] A_TX   = 32'h3000_0000;
    localparam logic [31:0] A_RX   = 32'h3000_0004;
    localparam logic [31:0] A_STAT = 32'h3000_0008;
    localparam logic [31:0] A_CTRL = 32'h3000_000C;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        acked;
        int          lat;

        vecs[0]  = '{A_STAT,        1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_000A};
        vecs[1]  = '{A_TX,          1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0};
        vecs[2]  = '{A_TX,          1'b1, 32'h1234_5678, 4'h0, 1'b1, 32'h0};
        vecs[3]  = '{A_STAT,        1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0208};
        vecs[4]  = '{A_TX,          1'b0, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[5]  = '{A_CTRL,        1'b1, 32'h1,         4'hE, 1'b1, 32'h0};
        vecs[6]  = '{A_CTRL,        1'b0, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[7]  = '{A_CTRL,        1'b1, 32'h1,         4'h1, 1'b1, 32'h0};
        vecs[8]  = '{A_CTRL,        1'b0, 32'h0,         4'hF, 1'b1, 32'h1};
        vecs[9]  = '{A_STAT,        1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
        vecs[10] = '{A_STAT,        1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0208};
        vecs[11] = '{32'h3000_0010, 1'b0, 32'h0,         4'hF, 1'b0, 32'h0};
        vecs[12] = '{A_RX,          1'b1, 32'h11,        4'hF, 1'b1, 32'h0};
        vecs[13] = '{32'h3000_000B, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0208};
        vecs[14] = '{A_CTRL,        1'b1, 32'h0,         4'h1, 1'b1, 32'h0};

        do_reset();

        for (int i = 0; i < 15; i++) begin
            bus(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, rd, acked, lat);
            chk($sformatf("vec%0d_ack", i), {31'b0, acked}, {31'b0, vecs[i].exp_ack});
            if (vecs[i].exp_ack) begin
                chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_rd);
                chk($sformatf("vec%0d_latency", i), lat, 32'd1);
            end
            if (i == 0) begin
                @(negedge clk);
                chk("ack_one_cycle", {31'b0, ack}, 32'h0);
            end
        end

        chk("tx_valid_2", {31'b0, tx_valid}, 32'h1);
        chk("tx_head_0", tx_data, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("tx_head_stable", tx_data, 32'hDEAD_BEEF);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("tx_head_1", tx_data, 32'h1234_5678);
        expect_read("status_tx1", A_STAT, 32'h0000_0108);

        // TX overflow and sticky clear
        do_reset();
        for (int i = 0; i < 9; i++) expect_write($sformatf("ovf_wr%0d", i), A_TX, 32'h100 + i);
        expect_read("status_ovf", A_STAT, 32'h0100_0809);
        chk("ovf_head", tx_data, 32'h100);
        bus(A_CTRL, 1'b1, 32'h4, 4'h1, rd, acked, lat);
        expect_read("status_ovf_clr", A_STAT, 32'h0000_0809);

        // RX fill, overfill, drain, underflow
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("rx_ready_%0d", i), {31'b0, rx_ready}, 32'h1);
            rx_data = 32'hA5A5_0001 + i;
            rx_valid = 1'b1;
        end
        @(negedge clk);
        chk("rx_ready_full", {31'b0, rx_ready}, 32'h0);
        rx_data = 32'hBAD0_BAD0;
        @(negedge clk);
        rx_valid = 1'b0;
        expect_read("status_rx_full", A_STAT, 32'h0008_0006);
        for (int i = 0; i < 8; i++)
            expect_read($sformatf("rx_pop%0d", i), A_RX, 32'hA5A5_0001 + i);
        expect_read("rx_pop_empty", A_RX, 32'h0);
        expect_read("status_unf", A_STAT, 32'h0200_000A);

        // Interrupt timing
        do_reset();
        bus(A_CTRL, 1'b1, 32'h1, 4'h1, rd, acked, lat);
        @(negedge clk);
        rx_data = 32'h0000_CAFE;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("irq_not_yet", {31'b0, irq}, 32'h0);
        @(negedge clk);
        chk("irq_set", {31'b0, irq}, 32'h1);
        bus(A_RX, 1'b0, 32'h0, 4'hF, rd, acked, lat);
        chk("irq_pop_data", rd, 32'h0000_CAFE);
        chk("irq_at_pop_ack", {31'b0, irq}, 32'h1);
        @(negedge clk);
        chk("irq_cleared", {31'b0, irq}, 32'h0);
        bus(32'h3000_0010, 1'b1, 32'h1, 4'hF, rd, acked, lat);
        chk("miss_write_ack", {31'b0, acked}, 32'h0);

        // Flush against a simultaneous RX push
        do_reset();
        for (int i = 0; i < 4; i++) expect_write($sformatf("fl_tx%0d", i), A_TX, 32'h200 + i);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_data = 32'h300 + i;
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        expect_read("status_half", A_STAT, 32'h0004_0400);
        @(negedge clk);
        adr = A_CTRL; we = 1'b1; wdat = 32'h2; sel = 4'h1; cyc = 1'b1; stb = 1'b1;
        rx_data = 32'h5555_5555; rx_valid = 1'b1;
        @(negedge clk);
        chk("flush_ack", {31'b0, ack}, 32'h1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rx_valid = 1'b0;
        chk("flush_tx_valid", {31'b0, tx_valid}, 32'h0);
        expect_read("status_flushed", A_STAT, 32'h0000_000A);
        expect_read("ctrl_after_flush", A_CTRL, 32'h0);

        // Reset while a request is pending and with sticky flags set
        for (int i = 0; i < 9; i++) expect_write($sformatf("mr_wr%0d", i), A_TX, 32'h400 + i);
        @(negedge clk);
        adr = A_STAT; we = 1'b0; cyc = 1'b1; stb = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        chk("mr_no_ack0", {31'b0, ack}, 32'h0);
        @(negedge clk);
        chk("mr_no_ack1", {31'b0, ack}, 32'h0);
        cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
        expect_read("status_after_mr", A_STAT, 32'h0000_000A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
